// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: turns UART byte commands into single 32-bit Wishbone transactions
module uart_wb_bridge #(
  parameter int wb_timeout = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WB, RESP} state_t;
  state_t state, state_n;
  logic we, we_n, ack_q, tx_gap, take, send, wb_done;
  logic [1:0] cnt, cnt_n;
  logic [2:0] rn, rn_n;
  logic [9:0] tmo, tmo_n;
  logic [31:0] adr_n, dat_n, rbuf, rbuf_n;
  logic [7:0] tx_data_n;
  // a byte is taken in a receiving state unless it was just acknowledged last cycle
  assign take = reset && rx_avail && !ack_q && (state == IDLE || state == ADDR || state == DATA);
  // transmit only when the uart is idle and at least one cycle has passed since the last strobe
  assign send = state == RESP && !tx_wr && !tx_gap && !tx_busy;
  // the bus cycle lasts exactly as long as the WB state, so a late ack cannot restart it
  assign wb_done = wb_ack_i || tmo == 10'(wb_timeout - 1);
  assign rx_ack = take;
  assign wb_cyc_o = state == WB;
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o = wb_cyc_o && we;
  assign wb_sel_o = {4{wb_cyc_o}};
  // command parser, bus sequencer and reply queue next-state logic
  always_comb begin
    state_n = state;
    we_n = we;
    cnt_n = cnt;
    rn_n = rn;
    tmo_n = state == WB ? tmo + 10'd1 : 10'd0;
    adr_n = wb_adr_o;
    dat_n = wb_dat_o;
    rbuf_n = rbuf;
    tx_data_n = tx_data;
    case (state)
      IDLE: if (take) begin
        we_n = rx_data == 8'h77;
        cnt_n = 2'd0;
        state_n = (rx_data == 8'h77 || rx_data == 8'h72) ? ADDR : RESP;
        rbuf_n = {8'h3F, 24'h0};
        rn_n = 3'd1;
      end
      ADDR: if (take) begin
        adr_n = {wb_adr_o[23:0], rx_data};
        cnt_n = cnt + 2'd1;
        state_n = cnt != 2'd3 ? ADDR : we ? DATA : WB;
      end
      DATA: if (take) begin
        dat_n = {wb_dat_o[23:0], rx_data};
        cnt_n = cnt + 2'd1;
        state_n = cnt == 2'd3 ? WB : DATA;
      end
      WB: if (wb_done) begin
        state_n = RESP;
        rn_n = wb_ack_i && !we ? 3'd4 : 3'd1;
        rbuf_n = !wb_ack_i ? {8'h21, 24'h0} : we ? {8'h2E, 24'h0} : wb_dat_i;
      end
      RESP: if (send) begin
        tx_data_n = rbuf[31:24];
        rbuf_n = {rbuf[23:0], 8'h0};
        rn_n = rn - 3'd1;
        state_n = rn == 3'd1 ? IDLE : RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      we <= 1'b0;
      cnt <= 2'd0;
      rn <= 3'd0;
      tmo <= 10'd0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      rbuf <= 32'h0;
      tx_data <= 8'h0;
      tx_wr <= 1'b0;
      tx_gap <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= state_n;
      we <= we_n;
      cnt <= cnt_n;
      rn <= rn_n;
      tmo <= tmo_n;
      wb_adr_o <= adr_n;
      wb_dat_o <= dat_n;
      rbuf <= rbuf_n;
      tx_data <= tx_data_n;
      tx_wr <= send;
      tx_gap <= tx_wr;
      ack_q <= take;
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: scoreboard bench for the UART to Wishbone bridge
module tb_uart_wb_bridge;
  logic clk = 0, reset = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_avail = 0, rx_ack, tx_wr;
  logic tx_busy = 0, hold_busy = 0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i, rd_val = 0;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic slave_ack = 0, late_ack = 0, cyc_q = 0;
  int checks = 0, errors = 0, rx_cnt = 0, tx_cnt = 0, cyc_cnt = 0, len = 0, busy_cnt = 0;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; int ack_at; int len;} wb_t;
  wb_t exp_wb[$];
  wb_t cur;
  logic [7:0] exp_tx[$];

  uart_wb_bridge dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;
  assign wb_ack_i = slave_ack | late_ack;
  assign wb_dat_i = wb_ack_i ? rd_val : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // uart transmitter model and reply monitor
  always @(negedge clk) begin
    if (tx_wr) begin
      tx_cnt++;
      check("tx_busy_at_wr", 64'(tx_busy), 64'(0));
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %0h, required none", tx_data);
      end else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      busy_cnt = 3;
    end else if (busy_cnt > 0) busy_cnt--;
    tx_busy = hold_busy || busy_cnt > 0;
  end

  // wishbone slave model and bus monitor
  always @(negedge clk) begin
    if (wb_cyc_o) begin
      if (!cyc_q) begin
        cyc_cnt++;
        len = 0;
        if (exp_wb.size() == 0) begin
          checks++;
          errors++;
          cur = '{0, 0, 0, 0, -1};
          $display("FAIL wb_unexpected: cycle at adr %0h, required none", wb_adr_o);
        end else begin
          cur = exp_wb.pop_front();
          check("wb_adr", 64'(wb_adr_o), 64'(cur.adr));
          check("wb_we", 64'(wb_we_o), 64'(cur.we));
          check("wb_sel", 64'(wb_sel_o), 64'(4'hF));
          check("wb_stb", 64'(wb_stb_o), 64'(1));
          if (cur.we) check("wb_dat", 64'(wb_dat_o), 64'(cur.dat));
        end
      end
      len++;
      slave_ack = cur.ack_at != 0 && len == cur.ack_at;
    end else begin
      if (cyc_q) begin
        check("wb_len", 64'(len), 64'(cur.len));
        check("wb_stb_off", 64'(wb_stb_o), 64'(0));
      end
      slave_ack = 0;
    end
    cyc_q = wb_cyc_o;
  end

  // counts rx_ack pulses, sampled mid-cycle
  always begin
    @(negedge clk);
    #2;
    if (rx_ack) rx_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b;
    rx_avail = 1;
    #1;
    while (!rx_ack && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rx_ack) begin
      checks++;
      errors++;
      $display("FAIL rx_ack_timeout: byte %0h not taken, required rx_ack", b);
    end else @(posedge clk);
    #1;
    rx_avail = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int ack_at, input int l);
    exp_wb.push_back('{we, adr, dat, ack_at, l});
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d tx and %0d wb outstanding, required 0", exp_tx.size(), exp_wb.size());
      exp_tx.delete();
      exp_wb.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"}, 64'({rx_ack, tx_wr, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(0));
    check({name, "_adr"}, 64'(wb_adr_o), 64'(0));
    check({name, "_dat"}, 64'(wb_dat_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int r0, t0, c0;
    rx_data = 8'h77;
    rx_avail = 1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    rx_avail = 0;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    push_wb(1, 32'h10000004, 32'hDEADBEEF, 4, 4);
    exp_tx.push_back(8'h2E);
    send_byte(8'h77);
    send_word(32'h10000004);
    send_word(32'hDEADBEEF);
    wait_done();
    rd_val = 32'h12345678;
    push_wb(0, 32'h40000000, 0, 2, 2);
    push_word(32'h12345678);
    send_byte(8'h72);
    send_word(32'h40000000);
    wait_done();
    push_wb(0, 32'h00000008, 0, 0, 1023);
    exp_tx.push_back(8'h21);
    send_byte(8'h72);
    send_word(32'h00000008);
    wait_done();
    c0 = cyc_cnt;
    t0 = tx_cnt;
    @(negedge clk);
    late_ack = 1;
    @(negedge clk);
    late_ack = 0;
    repeat (20) @(negedge clk);
    check("late_ack_cyc", 64'(cyc_cnt - c0), 64'(0));
    check("late_ack_tx", 64'(tx_cnt - t0), 64'(0));
    push_wb(1, 32'h0000000C, 32'h01020304, 1023, 1023);
    exp_tx.push_back(8'h2E);
    send_byte(8'h77);
    send_word(32'h0000000C);
    send_word(32'h01020304);
    wait_done();
    r0 = rx_cnt;
    exp_tx.push_back(8'h3F);
    send_byte(8'h67);
    rd_val = 32'hA5A55A5A;
    push_wb(0, 32'h00000000, 0, 1, 1);
    push_word(32'hA5A55A5A);
    send_byte(8'h72);
    send_word(32'h00000000);
    wait_done();
    check("unknown_rx_count", 64'(rx_cnt - r0), 64'(6));
    hold_busy = 1;
    r0 = rx_cnt;
    t0 = tx_cnt;
    exp_tx.push_back(8'h3F);
    @(negedge clk);
    rx_data = 8'h67;
    rx_avail = 1;
    repeat (3) @(negedge clk);
    rx_avail = 0;
    check("held_rx_count", 64'(rx_cnt - r0), 64'(1));
    repeat (500) @(negedge clk);
    check("busy_withheld", 64'(tx_cnt - t0), 64'(0));
    hold_busy = 0;
    wait_done();
    check("busy_released", 64'(tx_cnt - t0), 64'(1));
    r0 = rx_cnt;
    rd_val = 32'hCAFEBABE;
    push_wb(0, 32'h00000044, 0, 1, 1);
    push_word(32'hCAFEBABE);
    @(negedge clk);
    rx_data = 8'h72;
    rx_avail = 1;
    repeat (2) @(negedge clk);
    rx_avail = 0;
    send_word(32'h00000044);
    wait_done();
    check("ignore_cycle_rx_count", 64'(rx_cnt - r0), 64'(5));
    send_byte(8'h77);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    push_wb(1, 32'h00000020, 32'hCAFEF00D, 2, 2);
    exp_tx.push_back(8'h2E);
    send_byte(8'h77);
    send_word(32'h00000020);
    send_word(32'hCAFEF00D);
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
